pipe_reg_ctrl: RTL
==================

PIPE_REG_CTRL -- requirements
Module: pipe_reg_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the data payload per stage.
REQ-002 SHALL have parameter CTRL_W, default 8, meaning the width of the control bundle per stage (RegWrite, MemRead and similar).
REQ-003 SHALL have parameter DEPTH, default 1, legal range 1..4, meaning the number of register stages.
REQ-004 SHALL have parameter CNT_W, default 16, meaning the width of each event counter.
REQ-005 SHALL provide port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL provide port start_i, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL provide port stall_i, input, 1, memory stall; freeze all stages.
REQ-008 SHALL provide port flush_i, input, 1, kill all in-flight entries.
REQ-009 SHALL provide port bubble_i, input, 1, insert a bubble into stage 0 while older stages advance.
REQ-010 SHALL provide port clr_cnt_i, input, 1, synchronous clear of both counters.
REQ-011 SHALL provide port valid_i, input, 1, the incoming entry is real.
REQ-012 SHALL provide port ctrl_i, input, CTRL_W, the incoming control bundle.
REQ-013 SHALL provide port data_i, input, DATA_W, the incoming payload.
REQ-014 SHALL provide port valid_o, output, 1, last-stage valid.
REQ-015 SHALL provide port ctrl_o, output, CTRL_W, last-stage control.
REQ-016 SHALL provide port data_o, output, DATA_W, last-stage payload.
REQ-017 SHALL provide port stall_cnt_o, output, CNT_W, the number of stalled cycles.
REQ-018 SHALL provide port flush_cnt_o, output, CNT_W, the number of applied flushes.

Function
REQ-019 SHALL drive valid_o, ctrl_o and data_o directly from last-stage registers; latency from input to output is DEPTH cycles when not stalled.
REQ-020 SHALL hold every stage, all fields, on any edge where stall_i=1, regardless of flush_i and bubble_i.
REQ-021 SHALL set flush_pend=1 when flush_i=1 and stall_i=1.
REQ-022 SHALL keep flush_pend=1 until the first edge with stall_i=0, and then clear it.
REQ-023 SHALL, on an edge with stall_i=0 and (flush_i or flush_pend), clear valid and ctrl in every stage, load data of every stage unchanged-by-shift (don't-care, data_i for stage 0), and increment flush_cnt.
REQ-024 SHALL, on an edge with stall_i=0, no flush, and bubble_i=1, shift stages k>0 from k-1 and load stage 0 with valid=0, ctrl=0, data=data_i.
REQ-025 SHALL, on an edge with stall_i=0, no flush and no bubble, shift stages k>0 from k-1 and load stage 0 with valid_i, ctrl_i and data_i.
REQ-026 SHALL enforce the invariant that any stage with valid=0 holds ctrl=0; valid_i=0 therefore loads ctrl=0 irrespective of ctrl_i.
REQ-027 SHALL apply the priority reset > stall > flush (including pending) > bubble > normal load.
REQ-028 SHALL increment stall_cnt on every edge with stall_i=1.
REQ-029 SHALL make both counters saturate at 2^CNT_W-1 and never wrap.
REQ-030 SHALL, when clr_cnt_i=1, zero both counters on that edge, overriding any increment in the same cycle.
REQ-031 SHALL count a flush that is issued during a stall once, when it is applied.
REQ-032 SHALL treat flush_i held across both the stalled and the release edge as a single flush.

Reset
REQ-033 SHALL, while start_i=0, immediately force all stage valid, ctrl and data to 0, flush_pend to 0, and stall_cnt_o and flush_cnt_o to 0, independent of clk_i.
REQ-034 SHALL abandon any in-flight pending flush or stall on reset assertion; the first rising clk_i edge after start_i rises behaves as a normal cycle.

Structure
REQ-035 SHALL place parameter defaults, the DEPTH legal range and a stage-record typedef (valid, ctrl, data) in shared package pipe_pkg.
REQ-036 SHALL implement one stage as sub-module pipe_stage, with hold/clear/load controls and asynchronous active-low reset, instantiated DEPTH times by generate.
REQ-037 SHALL keep flush_pend and the counters in the top module.
REQ-038 SHALL reject DEPTH outside 1..4 at elaboration.

Verification
REQ-039 SHALL verify latency: DEPTH=3, one entry valid_i=1, ctrl_i=8'h5A, data_i=32'hDEADBEEF -> valid_o=1, ctrl_o=5A, data_o=DEADBEEF exactly 3 edges later, and for one cycle only.
REQ-040 SHALL verify stall: DEPTH=1, stall_i=1 for 4 cycles after loading 32'h1234 -> data_o stays 1234 and stall_cnt_o=4.
REQ-041 SHALL verify a flush during stall: DEPTH=2, both stages valid, flush_i pulsed for 1 cycle while stall_i=1, then stall_i released -> outputs unchanged during the stall, valid_o=0 and ctrl_o=0 after the release edge, flush_cnt_o=1.
REQ-042 SHALL verify bubble: DEPTH=2, valid entries A then B, bubble_i=1 on the edge that would load C -> output sequence A, B, then valid_o=0 with ctrl_o=0.
REQ-043 SHALL verify saturation and clear: CNT_W=4, stall_i=1 for 20 cycles -> stall_cnt_o=15; clr_cnt_i=1 with stall_i=1 -> 0 on that edge.
REQ-044 SHALL verify asynchronous reset: start_i dropped mid-cycle with valid data in flight -> all outputs 0 before the next clk_i edge, and flush_pend cleared.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register controller: parameter defaults,
// the legal DEPTH range, the stage record and the per-stage operation encoding.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int DEPTH_DEF  = 1;
    localparam int CNT_W_DEF  = 16;

    localparam int DEPTH_MIN  = 1;
    localparam int DEPTH_MAX  = 4;

    // One stage record at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } stage_t;

    typedef enum logic [1:0] {
        STAGE_HOLD  = 2'd0,
        STAGE_CLEAR = 2'd1,
        STAGE_LOAD  = 2'd2
    } stage_op_e;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: holds, clears (valid/ctrl to 0, data loaded),
// or loads a new entry, keeping ctrl at 0 whenever valid is 0.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  stage_op_e         op_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves a latch.
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        case (op_i)
            STAGE_LOAD: begin
                valid_d = valid_i;
                ctrl_d  = valid_i ? ctrl_i : '0;
                data_d  = data_i;
            end
            STAGE_CLEAR: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                data_d  = data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the payload is reset along with valid/ctrl so that outputs read as all-zero during reset.
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_ctrl.sv
// Pipeline register chain with stall, flush (deferred across stalls) and bubble
// control, plus saturating stall and flush event counters.
module pipe_reg_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              bubble_i,
    input  logic              clr_cnt_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_reg_ctrl: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              st_valid [DEPTH];
    logic [CTRL_W-1:0] st_ctrl  [DEPTH];
    logic [DATA_W-1:0] st_data  [DEPTH];

    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;
    logic              flush_apply;
    stage_op_e         op_head, op_body;

    assign flush_apply = !stall_i && (flush_i || flush_pend_q);

    always_comb begin
        op_head = STAGE_LOAD;
        op_body = STAGE_LOAD;
        if (stall_i) begin
            op_head = STAGE_HOLD;
            op_body = STAGE_HOLD;
        end else if (flush_apply) begin
            op_head = STAGE_CLEAR;
            op_body = STAGE_CLEAR;
        end else if (bubble_i) begin
            op_head = STAGE_CLEAR;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_stage (
                .clk_i   (clk_i),
                .rst_ni  (start_i),
                .op_i    (op_head),
                .valid_i (valid_i),
                .ctrl_i  (ctrl_i),
                .data_i  (data_i),
                .valid_o (st_valid[k]),
                .ctrl_o  (st_ctrl[k]),
                .data_o  (st_data[k])
            );
        end else begin : g_body
            pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_stage (
                .clk_i   (clk_i),
                .rst_ni  (start_i),
                .op_i    (op_body),
                .valid_i (st_valid[k-1]),
                .ctrl_i  (st_ctrl[k-1]),
                .data_i  (st_data[k-1]),
                .valid_o (st_valid[k]),
                .ctrl_o  (st_ctrl[k]),
                .data_o  (st_data[k])
            );
        end
    end

    // A flush seen while stalled is remembered and applied (and counted) once on release.
    always_comb begin
        flush_pend_d = stall_i ? (flush_pend_q || flush_i) : 1'b0;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall_i && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_apply && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign valid_o     = st_valid[DEPTH-1];
    assign ctrl_o      = st_ctrl[DEPTH-1];
    assign data_o      = st_data[DEPTH-1];
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
